// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BOOT_LEN_WIDTH = 16;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // True in the states that still consume image bytes.
  function automatic logic is_loading(input logic [2:0] s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  import imem_boot_loader_pkg::*;

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Packs accepted data bytes into little-endian 32-bit words.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // Byte index and shift register of the first three bytes (b2,b1,b0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_byte_valid) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word_valid = i_byte_valid && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_shift};
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a checksummed program image, writes it to
// instruction memory and releases the core once it verifies.
module imem_boot_loader #(
  parameter int DATA_WIDTH = imem_boot_loader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_boot_loader_if.slave    bus,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error,
  input  logic                 reload
);
  import imem_boot_loader_pkg::*;

  localparam logic [BOOT_LEN_WIDTH:0] LP_CAP = (BOOT_LEN_WIDTH+1)'(1) << ADDR_WIDTH;

  logic [2:0]                r_state;
  logic                      r_rx_ready;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_cpu_rst;
  logic                      r_done;
  logic                      r_error;
  logic [BOOT_LEN_WIDTH-1:0] r_len;
  logic [BOOT_LEN_WIDTH-1:0] r_word_cnt;
  logic [7:0]                r_xor;

  logic                      w_accept;
  logic                      w_clr;
  logic                      w_word_valid;
  logic [31:0]               w_word;
  logic [BOOT_LEN_WIDTH-1:0] w_len_full;
  logic                      w_last_word;

  assign w_accept    = bus.rx_valid && r_rx_ready;
  assign w_clr       = reload && ((r_state == S_DONE) || (r_state == S_ERROR));
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_last_word = (r_word_cnt == (r_len - 1'b1));

  boot_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_byte_valid (w_accept && (r_state == S_DATA)),
    .i_byte       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Load FSM, running XOR, word counter, write strobe and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_LEN_LO;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_xor      <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_we)
        r_addr <= r_addr + 1'b1;
      if (w_word_valid) begin
        r_we       <= 1'b1;
        r_wdata    <= DATA_WIDTH'(w_word);
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_accept)
        r_xor <= r_xor ^ bus.rx_data;
      // Ready rises one cycle after reset release; the terminal
      // transitions below override it on the same edge.
      if (is_loading(r_state))
        r_rx_ready <= 1'b1;

      case (r_state)
        S_LEN_LO: if (w_accept) begin
          r_len[7:0] <= bus.rx_data;
          r_state    <= S_LEN_HI;
        end
        S_LEN_HI: if (w_accept) begin
          r_len[15:8] <= bus.rx_data;
          if ({1'b0, w_len_full} > LP_CAP) begin
            r_state    <= S_ERROR;
            r_rx_ready <= 1'b0;
            r_error    <= 1'b1;
          end else if (w_len_full == '0) begin
            r_state <= S_CSUM;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_word_valid && w_last_word)
          r_state <= S_CSUM;
        S_CSUM: if (w_accept) begin
          r_rx_ready <= 1'b0;
          if (bus.rx_data == r_xor) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end
        end
        S_DONE, S_ERROR: if (reload) begin
          r_state    <= S_LEN_LO;
          r_rx_ready <= 1'b1;
          r_done     <= 1'b0;
          r_error    <= 1'b0;
          r_cpu_rst  <= 1'b1;
          r_addr     <= '0;
          r_word_cnt <= '0;
          r_len      <= '0;
          r_xor      <= '0;
        end
        default: r_state <= S_LEN_LO;
      endcase
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_rst        = r_cpu_rst;
  assign done           = r_done;
  assign error          = r_error;
endmodule
